// File: rtl/bvh_node_box_sched.sv
// Issues one BVH node's child boxes to a shared slab unit, one per cycle in index order,
// then reports the t_max-culled hit mask and the nearest hit child.
module bvh_node_box_sched #(
   parameter int N        = 4,
   parameter int SLAB_LAT = 1,
   localparam int IW      = (N > 1) ? $clog2(N) : 1,
   localparam int CW      = $clog2(N + 1) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [95:0]       ray_org,
   input  logic [95:0]       ray_invd,
   input  logic [31:0]       ray_tmax,
   input  logic [N-1:0]      child_mask,
   input  logic [N*96-1:0]   child_bmin,
   input  logic [N*96-1:0]   child_bmax,
   output logic              slab_valid_in,
   output logic [95:0]       slab_org,
   output logic [95:0]       slab_invd,
   output logic [95:0]       slab_bmin,
   output logic [95:0]       slab_bmax,
   input  logic              slab_ready,
   input  logic              slab_hit,
   input  logic [31:0]       slab_t_near,
   input  logic [31:0]       slab_t_far,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [N-1:0]      out_hit_mask,
   output logic              out_any_hit,
   output logic [IW-1:0]     out_nearest_idx,
   output logic [31:0]       out_nearest_t
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   localparam logic [31:0] T_INF = 32'h7FFF_FFFF;

   state_t              r_state;
   state_t              w_state_next;
   logic [95:0]         r_org;
   logic [95:0]         r_invd;
   logic [31:0]         r_tmax;
   logic [N*96-1:0]     r_bmin;
   logic [N*96-1:0]     r_bmax;
   logic [N-1:0]        r_pend;
   logic [CW-1:0]       r_cnt;
   logic [IW-1:0]       r_tag [SLAB_LAT];
   logic [N-1:0]        r_hit_mask;
   logic [IW-1:0]       r_nearest_idx;
   logic [31:0]         r_nearest_t;

   logic [95:0]         w_box_lo [N];
   logic [95:0]         w_box_hi [N];
   logic [IW-1:0]       w_issue_idx;
   logic [N-1:0]        w_pend_after;
   logic                w_issue;
   logic                w_accept;
   logic                w_last;
   logic                w_res_ok;
   logic [IW-1:0]       w_res_idx;
   logic                w_qual;
   logic [31:0]         w_key;
   logic                w_closer;
   logic [CW-1:0]       w_cnt_next;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_box
         assign w_box_lo[gi] = r_bmin[gi*96 +: 96];
         assign w_box_hi[gi] = r_bmax[gi*96 +: 96];
      end
   endgenerate

   // Lowest pending child wins, giving ascending issue order.
   always_comb begin
      w_issue_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (r_pend[i]) w_issue_idx = IW'(i);
      end
   end

   assign w_pend_after = r_pend & ~(N'(1) << w_issue_idx);
   assign w_last       = (w_pend_after == '0);
   assign w_accept     = (r_state == S_IDLE) && in_valid;

   // A result with nothing outstanding is stale (e.g. issued before a reset) and is dropped.
   assign w_res_ok   = slab_ready && (r_cnt != '0);
   assign w_res_idx  = r_tag[SLAB_LAT-1];
   assign w_qual     = w_res_ok && slab_hit && ($signed(slab_t_near) <= $signed(r_tmax));
   assign w_key      = slab_t_near[31] ? 32'd0 : slab_t_near;
   assign w_closer   = w_qual && ($signed(w_key) < $signed(r_nearest_t));
   assign w_cnt_next = r_cnt + CW'(w_issue) - CW'(w_res_ok);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (in_valid) w_state_next = (child_mask == '0) ? S_DONE : S_ISSUE;
         S_ISSUE: if (w_last) w_state_next = S_DRAIN;
         S_DRAIN: if (w_cnt_next == '0) w_state_next = S_DONE;
         S_DONE:  if (out_ready) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready      = (r_state == S_IDLE) && !rst;
      w_issue       = (r_state == S_ISSUE);
      slab_valid_in = w_issue;
      out_valid     = (r_state == S_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_org         <= '0;
         r_invd        <= '0;
         r_tmax        <= '0;
         r_bmin        <= '0;
         r_bmax        <= '0;
         r_pend        <= '0;
         r_cnt         <= '0;
         r_hit_mask    <= '0;
         r_nearest_idx <= '0;
         r_nearest_t   <= T_INF;
      end else begin
         r_cnt <= w_cnt_next;
         if (w_accept) begin
            r_org         <= ray_org;
            r_invd        <= ray_invd;
            r_tmax        <= ray_tmax;
            r_bmin        <= child_bmin;
            r_bmax        <= child_bmax;
            r_pend        <= child_mask;
            r_hit_mask    <= '0;
            r_nearest_idx <= '0;
            r_nearest_t   <= T_INF;
         end else begin
            if (w_issue) r_pend <= w_pend_after;
            if (w_qual) r_hit_mask[w_res_idx] <= 1'b1;
            if (w_closer) begin
               r_nearest_idx <= w_res_idx;
               r_nearest_t   <= w_key;
            end
         end
      end
   end

   // Tag pipe mirrors the slab latency so each result finds its child index.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SLAB_LAT; i++) r_tag[i] <= '0;
      end else begin
         r_tag[0] <= w_issue_idx;
         for (int i = 1; i < SLAB_LAT; i++) r_tag[i] <= r_tag[i-1];
      end
   end

   assign slab_org        = r_org;
   assign slab_invd       = r_invd;
   assign slab_bmin       = w_box_lo[w_issue_idx];
   assign slab_bmax       = w_box_hi[w_issue_idx];
   assign out_hit_mask    = r_hit_mask;
   assign out_any_hit     = |r_hit_mask;
   assign out_nearest_idx = r_nearest_idx;
   assign out_nearest_t   = r_nearest_t;

endmodule

// File: tb/tb_bvh_node_box_sched.sv
// Scoreboard bench for bvh_node_box_sched: behavioural slab unit, expected issues/results
// queued at request time and popped by a monitor when the DUT presents them.
module tb_bvh_node_box_sched;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [95:0]   ray_org, ray_invd;
   logic [31:0]   ray_tmax;
   logic [N-1:0]  child_mask;
   logic [N*96-1:0] child_bmin, child_bmax;
   logic          slab_valid_in;
   logic [95:0]   slab_org, slab_invd, slab_bmin, slab_bmax;
   logic          slab_ready, slab_hit;
   logic [31:0]   slab_t_near, slab_t_far;
   logic          out_valid, out_ready;
   logic [N-1:0]  out_hit_mask;
   logic          out_any_hit;
   logic [1:0]    out_nearest_idx;
   logic [31:0]   out_nearest_t;

   bvh_node_box_sched #(.N(N), .SLAB_LAT(1)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .ray_org(ray_org), .ray_invd(ray_invd), .ray_tmax(ray_tmax),
      .child_mask(child_mask), .child_bmin(child_bmin), .child_bmax(child_bmax),
      .slab_valid_in(slab_valid_in), .slab_org(slab_org), .slab_invd(slab_invd),
      .slab_bmin(slab_bmin), .slab_bmax(slab_bmax),
      .slab_ready(slab_ready), .slab_hit(slab_hit),
      .slab_t_near(slab_t_near), .slab_t_far(slab_t_far),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_hit_mask(out_hit_mask), .out_any_hit(out_any_hit),
      .out_nearest_idx(out_nearest_idx), .out_nearest_t(out_nearest_t)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [3:0]  mask;
      logic [1:0]  idx;
      logic [31:0] t;
      int          cyc;
   } res_t;
   typedef struct {
      logic [95:0] bmin;
      int          cyc;
   } iss_t;

   res_t res_q[$];
   iss_t iss_q[$];

   int n_tests = 0;
   int n_fail  = 0;

   logic [95:0]    g_org, g_invd;
   logic [N*96-1:0] g_bmin, g_bmax;
   bit             inj = 0;

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] q(input int x);
      return 32'(x * 65536);
   endfunction

   function automatic logic [95:0] v3(input logic [31:0] v);
      return {v, v, v};
   endfunction

   task automatic put_box(input int i, input int lo, input int hi);
      g_bmin[i*96 +: 96] = v3(q(lo));
      g_bmax[i*96 +: 96] = v3(q(hi));
   endtask

   // Reference slab test in Q16.16.
   function automatic void slab(input logic [95:0] o, input logic [95:0] iv,
                                input logic [95:0] lo, input logic [95:0] hi,
                                output logic h, output logic [31:0] tn, output logic [31:0] tf);
      longint n, f, oo, ii, t0, t1;
      n = -(64'sd1 <<< 60);
      f = 64'sd1 <<< 60;
      for (int a = 0; a < 3; a++) begin
         oo = longint'($signed(o[a*32 +: 32]));
         ii = longint'($signed(iv[a*32 +: 32]));
         t0 = ((longint'($signed(lo[a*32 +: 32])) - oo) * ii) >>> 16;
         t1 = ((longint'($signed(hi[a*32 +: 32])) - oo) * ii) >>> 16;
         if (t0 > t1) begin
            longint tmp;
            tmp = t0; t0 = t1; t1 = tmp;
         end
         if (t0 > n) n = t0;
         if (t1 < f) f = t1;
      end
      h  = (n <= f) && (f >= 0);
      tn = n[31:0];
      tf = f[31:0];
   endfunction

   // Slab unit model: one-cycle latency, optional injected stale result.
   initial begin
      logic        pv, ph;
      logic [31:0] pn, pf;
      slab_ready  = 1'b0;
      slab_hit    = 1'b0;
      slab_t_near = '0;
      slab_t_far  = '0;
      forever begin
         @(negedge clk);
         pv = slab_valid_in;
         slab(slab_org, slab_invd, slab_bmin, slab_bmax, ph, pn, pf);
         @(posedge clk);
         #1;
         if (inj) begin
            slab_ready  = 1'b1;
            slab_hit    = 1'b1;
            slab_t_near = 32'd0;
            slab_t_far  = q(1);
         end else begin
            slab_ready  = pv;
            slab_hit    = ph;
            slab_t_near = pn;
            slab_t_far  = pf;
         end
      end
   end

   // Monitor: checks issues and results against the queued expectations.
   bit          seen = 0;
   logic [3:0]  snap_mask;
   logic [1:0]  snap_idx;
   logic [31:0] snap_t;
   iss_t        m_iss;
   res_t        m_res;

   initial begin
      forever begin
         @(negedge clk);
         if (slab_valid_in) begin
            if (iss_q.size() == 0) begin
               chk("unexpected_issue", 96'(slab_valid_in), 96'd0);
            end else begin
               m_iss = iss_q.pop_front();
               chk("issue_box", slab_bmin, m_iss.bmin);
               chk("issue_cycle", 96'(cyc), 96'(m_iss.cyc));
               chk("issue_org", slab_org, g_org);
               $display("[TB] issue cycle %0d bmin.x=%0h", cyc, slab_bmin[31:0]);
            end
         end
         if (out_valid) begin
            if (!seen) begin
               seen = 1;
               if (res_q.size() == 0) begin
                  chk("unexpected_result", 96'(out_valid), 96'd0);
               end else begin
                  m_res = res_q.pop_front();
                  chk("hit_mask", 96'(out_hit_mask), 96'(m_res.mask));
                  chk("any_hit", 96'(out_any_hit), 96'(|m_res.mask));
                  chk("nearest_idx", 96'(out_nearest_idx), 96'(m_res.idx));
                  chk("nearest_t", 96'(out_nearest_t), 96'(m_res.t));
                  chk("result_cycle", 96'(cyc), 96'(m_res.cyc));
                  $display("[TB] result cycle %0d mask=%b idx=%0d t=%h", cyc,
                           out_hit_mask, out_nearest_idx, out_nearest_t);
               end
               snap_mask = out_hit_mask;
               snap_idx  = out_nearest_idx;
               snap_t    = out_nearest_t;
            end else begin
               chk("hold_mask", 96'(out_hit_mask), 96'(snap_mask));
               chk("hold_idx", 96'(out_nearest_idx), 96'(snap_idx));
               chk("hold_t", 96'(out_nearest_t), 96'(snap_t));
               chk("hold_in_ready", 96'(in_ready), 96'd0);
            end
         end else begin
            seen = 0;
         end
      end
   end

   task automatic req(input logic [31:0] tmax, input logic [3:0] mask, input int max_iss,
                      input bit push_res, input logic [3:0] e_mask, input logic [1:0] e_idx,
                      input logic [31:0] e_t, output int c0);
      bit   got;
      int   k, j;
      iss_t e;
      res_t r;
      got = 0;
      for (int w = 0; w < 100 && !got; w++) begin
         @(posedge clk);
         #1;
         if (in_ready) got = 1;
      end
      chk("in_ready_wait", 96'(in_ready), 96'd1);
      ray_org    = g_org;
      ray_invd   = g_invd;
      ray_tmax   = tmax;
      child_mask = mask;
      child_bmin = g_bmin;
      child_bmax = g_bmax;
      in_valid   = 1'b1;
      c0 = cyc;
      k  = $countones(mask);
      j  = 0;
      for (int i = 0; i < N; i++) begin
         if (mask[i]) begin
            if (j < max_iss) begin
               e.bmin = g_bmin[i*96 +: 96];
               e.cyc  = c0 + 1 + j;
               iss_q.push_back(e);
            end
            j++;
         end
      end
      if (push_res) begin
         r.mask = e_mask;
         r.idx  = e_idx;
         r.t    = e_t;
         r.cyc  = (k == 0) ? c0 + 1 : c0 + k + 2;
         res_q.push_back(r);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      bit got;
      got = 0;
      for (int w = 0; w < budget && !got; w++) begin
         @(negedge clk);
         if (out_valid) got = 1;
      end
      chk("out_valid_wait", 96'(out_valid), 96'd1);
   endtask

   task automatic finish_txn();
      @(posedge clk);
      #1;
      chk("out_valid_drop", 96'(out_valid), 96'd0);
   endtask

   int c0;

   initial begin
      rst        = 1'b1;
      in_valid   = 1'b0;
      out_ready  = 1'b1;
      ray_org    = '0;
      ray_invd   = '0;
      ray_tmax   = '0;
      child_mask = '0;
      child_bmin = '0;
      child_bmax = '0;
      g_org      = '0;
      g_invd     = v3(q(1));
      g_bmin     = '0;
      g_bmax     = '0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 96'(in_ready), 96'd0);
      chk("rst_out_valid", 96'(out_valid), 96'd0);
      chk("rst_slab_valid", 96'(slab_valid_in), 96'd0);
      chk("rst_hit_mask", 96'(out_hit_mask), 96'd0);
      chk("rst_any_hit", 96'(out_any_hit), 96'd0);
      chk("rst_nearest_idx", 96'(out_nearest_idx), 96'd0);
      chk("rst_nearest_t", 96'(out_nearest_t), 96'h7FFF_FFFF);
      chk("rst_slab_org", slab_org, 96'd0);
      @(posedge clk);
      #2;
      rst = 1'b0;

      // Two boxes, both within t_max.
      put_box(0, 1, 2);
      put_box(1, 3, 4);
      req(32'h000A_0000, 4'b0011, 8, 1, 4'b0011, 2'd0, 32'h0001_0000, c0);
      wait_done(50);
      finish_txn();

      // t_max culls child 1.
      req(32'h0002_0000, 4'b0011, 8, 1, 4'b0001, 2'd0, 32'h0001_0000, c0);
      wait_done(50);
      finish_txn();

      // Sparse mask, nearer box at higher index.
      g_bmin = '0;
      g_bmax = '0;
      put_box(1, 5, 6);
      put_box(3, 2, 3);
      req(32'h000A_0000, 4'b1010, 8, 1, 4'b1010, 2'd3, 32'h0002_0000, c0);
      wait_done(50);
      finish_txn();

      // Empty node.
      req(32'h000A_0000, 4'b0000, 8, 1, 4'b0000, 2'd0, 32'h7FFF_FFFF, c0);
      wait_done(50);
      finish_txn();

      // Origin inside both boxes: clamp to 0, tie goes to index 0; consumer stalls.
      g_bmin = '0;
      g_bmax = '0;
      put_box(0, -2, 2);
      put_box(2, -1, 1);
      out_ready = 1'b0;
      req(32'h000A_0000, 4'b0101, 8, 1, 4'b0101, 2'd0, 32'h0000_0000, c0);
      wait_done(50);
      repeat (5) @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("stall_release_valid", 96'(out_valid), 96'd0);
      chk("stall_release_in_ready", 96'(in_ready), 96'd1);

      // Reset during the second issue cycle of a four-child node.
      put_box(0, 1, 2);
      put_box(1, 3, 4);
      put_box(2, 5, 6);
      put_box(3, 2, 3);
      req(32'h000A_0000, 4'b1111, 1, 0, 4'b0000, 2'd0, 32'h0, c0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_slab_valid", 96'(slab_valid_in), 96'd0);
      chk("midrst_out_valid", 96'(out_valid), 96'd0);
      chk("midrst_nearest_t", 96'(out_nearest_t), 96'h7FFF_FFFF);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("postrst_in_ready", 96'(in_ready), 96'd1);
      chk("postrst_slab_valid", 96'(slab_valid_in), 96'd0);
      inj = 1;
      @(posedge clk);
      #2;
      inj = 0;

      // Request after reset must not see the stale result.
      g_bmin = '0;
      g_bmax = '0;
      put_box(0, 1, 2);
      put_box(1, 3, 4);
      req(32'h000A_0000, 4'b0011, 8, 1, 4'b0011, 2'd0, 32'h0001_0000, c0);
      wait_done(50);
      finish_txn();

      repeat (3) @(posedge clk);
      #1;
      chk("issue_queue_empty", 96'(iss_q.size()), 96'd0);
      chk("result_queue_empty", 96'(res_q.size()), 96'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
